mdr_mem: RTL and testbench

Parametrised memory data register: the next generation of the CPU's MDR. It holds one data word between the internal bus and memory. It also runs its own read/write handshake with the memory port, aligns and sign- or zero-extends byte/halfword loads, and replicates store data with byte enables. It sits between the bus multiplexer (BusMuxOut/BusMuxIn) and the memory subsystem (Mdatain/Mdataout), under control of the control unit.

---
 rtl/mdr_mem.sv | 205 ++++++++++++++++++++
 tb/tb_mdr_mem.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_mem.sv
// Memory data register with its own read/write handshake to the memory port.
// Loads are lane-extracted and sign/zero-extended; stores are replicated with byte enables.
module mdr_mem #(
  parameter  int DATA_WIDTH = 32,
  localparam int OFF_W      = $clog2(DATA_WIDTH/8),
  localparam int NB         = DATA_WIDTH/8
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  read,
  input  logic                  write,
  input  logic [1:0]            size,
  input  logic                  unsigned_ld,
  input  logic [OFF_W-1:0]      addr_lo,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic [DATA_WIDTH-1:0] Mdatain,
  input  logic                  mem_ack,
  output logic [DATA_WIDTH-1:0] BusMuxIn,
  output logic [DATA_WIDTH-1:0] Mdataout,
  output logic [NB-1:0]         mem_be,
  output logic                  mem_rd_req,
  output logic                  mem_wr_req,
  output logic                  busy,
  output logic                  misaligned
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   q_q, q_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [OFF_W-1:0]        off_q, off_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic [NB-1:0]           be_q, be_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic                    busy_q, busy_d;
  logic                    mis_q, mis_d;

  function automatic int size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return NB;
    endcase
  endfunction

  // On a 32-bit datapath the word and full-width checks coincide.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [OFF_W-1:0] off);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return (off[1:0] != 2'b00);
      default: return (off != '0);
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_lane(input logic [DATA_WIDTH-1:0] d,
                                                      input logic [1:0] sz,
                                                      input logic uns,
                                                      input logic [OFF_W-1:0] off);
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] r;
    logic                  msb;
    int                    nbits;
    sh    = d >> {off, 3'b000};
    nbits = 8 * size_bytes(sz);
    msb   = ~uns & sh[nbits-1];
    for (int i = 0; i < DATA_WIDTH; i++) begin
      r[i] = (i < nbits) ? sh[i] : msb;
    end
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_data(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [1:0] sz);
    logic [DATA_WIDTH-1:0] r;
    int                    n;
    n = size_bytes(sz);
    for (int i = 0; i < NB; i++) begin
      r[8*i +: 8] = d[8*(i % n) +: 8];
    end
    return r;
  endfunction

  function automatic logic [NB-1:0] store_be(input logic [1:0] sz, input logic [OFF_W-1:0] off);
    logic [NB-1:0] r;
    int            n;
    int            o;
    n = size_bytes(sz);
    o = int'(off);
    for (int i = 0; i < NB; i++) begin
      r[i] = (i >= o) && (i < o + n);
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    dout_d  = dout_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // A rejected read still takes priority, so a simultaneous write is dropped.
        if (read) begin
          if (is_misaligned(size, addr_lo)) begin
            mis_d = 1'b1;
          end else begin
            size_d  = size;
            uns_d   = unsigned_ld;
            off_d   = addr_lo;
            rd_d    = 1'b1;
            busy_d  = 1'b1;
            state_d = READ;
          end
        end else if (write) begin
          if (is_misaligned(size, addr_lo)) begin
            mis_d = 1'b1;
          end else begin
            dout_d  = store_data(q_q, size);
            be_d    = store_be(size, addr_lo);
            wr_d    = 1'b1;
            busy_d  = 1'b1;
            state_d = WRITE;
          end
        end else if (enable) begin
          q_d = BusMuxOut;
        end
      end
      READ: begin
        if (mem_ack) begin
          q_d     = load_lane(Mdatain, size_q, uns_q, off_q);
          rd_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          dout_d  = '0;
          be_d    = '0;
          wr_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        dout_d  = '0;
        be_d    = '0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      q_q     <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      dout_q  <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      dout_q  <= dout_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      mis_q   <= mis_d;
    end
  end

  assign BusMuxIn   = q_q;
  assign Mdataout   = dout_q;
  assign mem_be     = be_q;
  assign mem_rd_req = rd_q;
  assign mem_wr_req = wr_q;
  assign busy       = busy_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_mdr_mem.sv
// Directed bench for mdr_mem: vector table for single transactions plus
// hand-written sequences for latency, contention and reset corners.
module tb_mdr_mem;

  logic        clock = 1'b0;
  logic        clear;
  logic        enable;
  logic        read;
  logic        write;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [1:0]  addr_lo;
  logic [31:0] BusMuxOut;
  logic [31:0] Mdatain;
  logic        mem_ack;
  logic [31:0] BusMuxIn;
  logic [31:0] Mdataout;
  logic [3:0]  mem_be;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic        busy;
  logic        misaligned;

  int total = 0;
  int bad   = 0;

  mdr_mem #(.DATA_WIDTH(32)) dut (
    .clock(clock), .clear(clear), .enable(enable), .read(read), .write(write),
    .size(size), .unsigned_ld(unsigned_ld), .addr_lo(addr_lo),
    .BusMuxOut(BusMuxOut), .Mdatain(Mdatain), .mem_ack(mem_ack),
    .BusMuxIn(BusMuxIn), .Mdataout(Mdataout), .mem_be(mem_be),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .busy(busy),
    .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_wr;
    logic [1:0]  sz;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] busin;
    logic [31:0] mdin;
    logic        exp_mis;
    logic [31:0] exp_q;
    logic [31:0] exp_dout;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vt[17];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", k);
    enable = 1'b1; BusMuxOut = v.busin;
    step();
    enable = 1'b0;
    chk({tag, " preload"}, BusMuxIn, v.busin);
    size = v.sz; unsigned_ld = v.uns; addr_lo = v.off; Mdatain = v.mdin;
    if (v.is_wr) write = 1'b1; else read = 1'b1;
    step();
    read = 1'b0; write = 1'b0;
    if (v.exp_mis) begin
      chk({tag, " mis"}, {31'd0, misaligned}, 32'd1);
      chk({tag, " no req"}, {30'd0, mem_rd_req, mem_wr_req}, 32'd0);
      chk({tag, " not busy"}, {31'd0, busy}, 32'd0);
      step();
      chk({tag, " mis pulse end"}, {31'd0, misaligned}, 32'd0);
      chk({tag, " q hold"}, BusMuxIn, v.busin);
    end else if (!v.is_wr) begin
      chk({tag, " rd_req"}, {31'd0, mem_rd_req}, 32'd1);
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk({tag, " q load"}, BusMuxIn, v.exp_q);
      chk({tag, " rd_req drop"}, {30'd0, busy, mem_rd_req}, 32'd0);
    end else begin
      chk({tag, " wr_req"}, {31'd0, mem_wr_req}, 32'd1);
      chk({tag, " dout"}, Mdataout, v.exp_dout);
      chk({tag, " be"}, {28'd0, mem_be}, {28'd0, v.exp_be});
      step();
      chk({tag, " dout held"}, Mdataout, v.exp_dout);
      chk({tag, " wr_req held"}, {31'd0, mem_wr_req}, 32'd1);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk({tag, " wr done"}, {30'd0, busy, mem_wr_req}, 32'd0);
      chk({tag, " idle dout"}, Mdataout, 32'd0);
      chk({tag, " idle be"}, {28'd0, mem_be}, 32'd0);
      chk({tag, " q kept"}, BusMuxIn, v.exp_q);
    end
  endtask

  initial begin
    int busy_cnt;
    vt[0]  = '{1'b0, 2'b00, 1'b0, 2'd3, 32'h11111111, 32'h80123456, 1'b0, 32'hFFFFFF80, 32'h0, 4'h0};
    vt[1]  = '{1'b0, 2'b00, 1'b1, 2'd3, 32'h11111111, 32'h80123456, 1'b0, 32'h00000080, 32'h0, 4'h0};
    vt[2]  = '{1'b0, 2'b01, 1'b0, 2'd2, 32'h22222222, 32'h80017FFF, 1'b0, 32'hFFFF8001, 32'h0, 4'h0};
    vt[3]  = '{1'b0, 2'b01, 1'b1, 2'd0, 32'h22222222, 32'h80017FFF, 1'b0, 32'h00007FFF, 32'h0, 4'h0};
    vt[4]  = '{1'b0, 2'b01, 1'b0, 2'd0, 32'h33333333, 32'h1234F00D, 1'b0, 32'hFFFFF00D, 32'h0, 4'h0};
    vt[5]  = '{1'b0, 2'b10, 1'b0, 2'd0, 32'h44444444, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 32'h0, 4'h0};
    vt[6]  = '{1'b0, 2'b11, 1'b1, 2'd0, 32'h44444444, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 32'h0, 4'h0};
    vt[7]  = '{1'b0, 2'b00, 1'b0, 2'd1, 32'h55555555, 32'h00007F00, 1'b0, 32'h0000007F, 32'h0, 4'h0};
    vt[8]  = '{1'b0, 2'b00, 1'b0, 2'd2, 32'h55555555, 32'h00FF0000, 1'b0, 32'hFFFFFFFF, 32'h0, 4'h0};
    vt[9]  = '{1'b1, 2'b00, 1'b0, 2'd1, 32'h000000AB, 32'h0, 1'b0, 32'h000000AB, 32'hABABABAB, 4'b0010};
    vt[10] = '{1'b1, 2'b01, 1'b0, 2'd2, 32'h1234BEEF, 32'h0, 1'b0, 32'h1234BEEF, 32'hBEEFBEEF, 4'b1100};
    vt[11] = '{1'b1, 2'b10, 1'b0, 2'd0, 32'h89ABCDEF, 32'h0, 1'b0, 32'h89ABCDEF, 32'h89ABCDEF, 4'b1111};
    vt[12] = '{1'b1, 2'b00, 1'b0, 2'd3, 32'h0000005A, 32'h0, 1'b0, 32'h0000005A, 32'h5A5A5A5A, 4'b1000};
    vt[13] = '{1'b0, 2'b10, 1'b0, 2'd2, 32'h11112222, 32'hFFFFFFFF, 1'b1, 32'h11112222, 32'h0, 4'h0};
    vt[14] = '{1'b0, 2'b01, 1'b0, 2'd1, 32'h33334444, 32'hFFFFFFFF, 1'b1, 32'h33334444, 32'h0, 4'h0};
    vt[15] = '{1'b1, 2'b11, 1'b0, 2'd1, 32'h5555AAAA, 32'h0, 1'b1, 32'h5555AAAA, 32'h0, 4'h0};
    vt[16] = '{1'b1, 2'b01, 1'b0, 2'd3, 32'h6666BBBB, 32'h0, 1'b1, 32'h6666BBBB, 32'h0, 4'h0};

    clear = 1'b0; enable = 1'b0; read = 1'b0; write = 1'b0; size = 2'b00;
    unsigned_ld = 1'b0; addr_lo = 2'd0; BusMuxOut = 32'd0; Mdatain = 32'd0; mem_ack = 1'b0;
    step();
    chk("reset q", BusMuxIn, 32'd0);
    chk("reset outs", {Mdataout[27:0], mem_be}, 32'd0);
    chk("reset ctl", {28'd0, mem_rd_req, mem_wr_req, busy, misaligned}, 32'd0);
    clear = 1'b1;
    step();

    for (int k = 0; k < 17; k++) run_vec(k, vt[k]);

    // Byte load with ack four edges after the request: busy for four cycles.
    size = 2'b00; unsigned_ld = 1'b0; addr_lo = 2'd3; Mdatain = 32'h80123456;
    read = 1'b1;
    step();
    read = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy) busy_cnt++;
      if (i == 3) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    chk("lat busy cycles", busy_cnt, 32'd4);
    chk("lat q", BusMuxIn, 32'hFFFFFF80);
    chk("lat busy low", {31'd0, busy}, 32'd0);

    // Contention: enable/read/write during READ are ignored.
    enable = 1'b1; BusMuxOut = 32'hAAAA5555;
    step();
    enable = 1'b0;
    size = 2'b10; addr_lo = 2'd0; read = 1'b1;
    step();
    enable = 1'b1; BusMuxOut = 32'h00001234; write = 1'b1;
    step();
    chk("cont q hold", BusMuxIn, 32'hAAAA5555);
    chk("cont no wr", {31'd0, mem_wr_req}, 32'd0);
    mem_ack = 1'b1; Mdatain = 32'h0BADF00D;
    step();
    mem_ack = 1'b0; enable = 1'b0; read = 1'b0; write = 1'b0;
    chk("cont q load", BusMuxIn, 32'h0BADF00D);
    step();
    chk("cont q stays", BusMuxIn, 32'h0BADF00D);

    // Read and write together: only the read is issued, write is not queued.
    read = 1'b1; write = 1'b1; size = 2'b10; addr_lo = 2'd0; Mdatain = 32'h01234567;
    step();
    read = 1'b0; write = 1'b0;
    chk("rw rd_req", {30'd0, mem_rd_req, mem_wr_req}, 32'd2);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("rw q", BusMuxIn, 32'h01234567);
    step();
    chk("rw no queued wr", {30'd0, mem_rd_req, mem_wr_req}, 32'd0);

    // Back-to-back misaligned reads: one pulse each.
    size = 2'b10; addr_lo = 2'd2; read = 1'b1;
    step();
    chk("mis b2b 1", {30'd0, misaligned, mem_rd_req}, 32'd2);
    step();
    read = 1'b0;
    chk("mis b2b 2", {30'd0, misaligned, mem_rd_req}, 32'd2);
    step();
    chk("mis b2b end", {31'd0, misaligned}, 32'd0);
    chk("mis b2b q", BusMuxIn, 32'h01234567);

    // Ack while idle is ignored.
    Mdatain = 32'hFFFFFFFF; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("idle ack q", BusMuxIn, 32'h01234567);

    // Asynchronous clear in the middle of a read.
    size = 2'b10; addr_lo = 2'd0; read = 1'b1;
    step();
    read = 1'b0;
    chk("clr pre rd_req", {31'd0, mem_rd_req}, 32'd1);
    #2 clear = 1'b0;
    #1;
    chk("clr q", BusMuxIn, 32'd0);
    chk("clr outs", {Mdataout[27:0], mem_be}, 32'd0);
    chk("clr ctl", {28'd0, mem_rd_req, mem_wr_req, busy, misaligned}, 32'd0);
    step();
    clear = 1'b1;
    Mdatain = 32'h76543210; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("clr ack q", BusMuxIn, 32'd0);
    chk("clr ack ctl", {30'd0, busy, mem_rd_req}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
